// File: rtl/jtag_scan_master.sv
`timescale 1ns/1ps
// Host-side JTAG sequencer: converts TAP-reset / IR-scan / DR-scan commands into
// TCK/TMS/TDI bit slots and returns the TDO bits captured during the shift phase.
module jtag_scan_master #(
    parameter int SHIFT_W = 256,
    parameter int LEN_W   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic               wb_clk_i,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [SHIFT_W-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [SHIFT_W-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic [2:0]         fsm_state
);

    // Handshakes: a command transfers on a cycle with cmd_valid & cmd_ready, a response
    // on a cycle with rsp_valid & rsp_ready; a raised valid holds its payload until then.

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_PRE    = 3'd2,
        S_SHIFT  = 3'd3,
        S_POST   = 3'd4,
        S_RSTSEQ = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   slot_q, slot_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;
    logic               tck_d, tms_d, tdi_d;
    logic               half_done;
    logic               accept;
    logic               capture;
    logic               is_ir_q;
    logic [LEN_W-1:0]   len_q;
    logic [SHIFT_W-1:0] data_q;

    function automatic logic slot_last(input state_t st, input logic [LEN_W-1:0] idx,
                                       input logic ir, input logic [LEN_W-1:0] len);
        logic r;
        case (st)
            S_INIT, S_RSTSEQ: r = (idx == LEN_W'(5));
            S_PRE:            r = (idx == (ir ? LEN_W'(3) : LEN_W'(2)));
            S_SHIFT:          r = (idx == len);
            S_POST:           r = (idx == LEN_W'(1));
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

    // TMS for a slot: IR walks Idle->SelDR->SelIR->Capture->Shift, DR skips SelIR.
    function automatic logic tms_for(input state_t st, input logic [LEN_W-1:0] idx,
                                     input logic ir, input logic [LEN_W-1:0] len);
        logic r;
        case (st)
            S_INIT, S_RSTSEQ: r = (idx < LEN_W'(5));
            S_PRE:            r = ir ? (idx < LEN_W'(2)) : (idx == LEN_W'(0));
            S_SHIFT:          r = (idx == len);
            S_POST:           r = (idx == LEN_W'(0));
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            slot_q  <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            TCK     <= 1'b0;
            TMS     <= 1'b1;
            TDI     <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            TCK     <= tck_d;
            TMS     <= tms_d;
            TDI     <= tdi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        div_d     = div_q;
        phase_d   = phase_q;
        tck_d     = TCK;
        tms_d     = TMS;
        tdi_d     = TDI;
        accept    = 1'b0;
        capture   = 1'b0;
        half_done = (div_q == DIV_W'(CLK_DIV - 1));
        case (state_q)
            S_IDLE: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    slot_d  = '0;
                    div_d   = '0;
                    phase_d = 1'b0;
                    case (cmd_op)
                        2'b00:        state_d = S_RSTSEQ;
                        2'b01, 2'b10: state_d = S_PRE;
                        default:      state_d = S_RESP;
                    endcase
                    // Every sequence opens with TMS=1; a reserved op never touches the TAP.
                    tms_d = (cmd_op != 2'b11);
                end
            end
            S_RESP: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                div_d = half_done ? '0 : div_q + DIV_W'(1);
                if (half_done && !phase_q) begin
                    tck_d   = 1'b1;
                    phase_d = 1'b1;
                    capture = (state_q == S_SHIFT);
                end else if (half_done && phase_q) begin
                    tck_d   = 1'b0;
                    phase_d = 1'b0;
                    if (slot_last(state_q, slot_q, is_ir_q, len_q)) begin
                        slot_d = '0;
                        case (state_q)
                            S_INIT:   state_d = S_IDLE;
                            S_PRE:    state_d = S_SHIFT;
                            S_SHIFT:  state_d = S_POST;
                            S_POST:   state_d = S_RESP;
                            S_RSTSEQ: state_d = S_RESP;
                            default:  state_d = S_IDLE;
                        endcase
                    end else begin
                        slot_d = slot_q + LEN_W'(1);
                    end
                    // Next slot's TMS/TDI are launched together with the falling TCK.
                    tms_d = tms_for(state_d, slot_d, is_ir_q, len_q);
                    tdi_d = (state_d == S_SHIFT) ? data_q[slot_d] : 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            is_ir_q  <= 1'b0;
            len_q    <= '0;
            data_q   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            is_ir_q  <= (cmd_op == 2'b01);
            len_q    <= cmd_len;
            data_q   <= cmd_data;
            rsp_data <= '0;
            rsp_err  <= (cmd_op == 2'b11);
        end else if (capture) begin
            rsp_data[slot_q] <= TDO;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
`timescale 1ns/1ps
// Directed bench for jtag_scan_master against a behavioural 3-bit-IR TAP with
// a 1-bit bypass register and a 253-bit boundary-scan register.
module tb_jtag_scan_master;

    localparam int SHIFT_W = 256;
    localparam int LEN_W   = 8;
    localparam int CLK_DIV = 2;

    logic               wb_clk_i  = 1'b0;
    logic               resetn    = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               rsp_ready = 1'b1;
    logic [1:0]         cmd_op    = 2'b00;
    logic [LEN_W-1:0]   cmd_len   = '0;
    logic [SHIFT_W-1:0] cmd_data  = '0;
    logic               cmd_ready, rsp_valid, rsp_err, busy;
    logic [SHIFT_W-1:0] rsp_data;
    logic               TCK, TMS, TDI;
    logic               TDO = 1'b0;
    logic [2:0]         fsm_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    jtag_scan_master #(.SHIFT_W(SHIFT_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .wb_clk_i (wb_clk_i),
        .resetn   (resetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .TCK      (TCK),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .fsm_state(fsm_state)
    );

    // ---------------- TCK edge log ----------------
    logic tms_log[$];
    logic tdi_log[$];
    always @(posedge TCK) begin
        tms_log.push_back(TMS);
        tdi_log.push_back(TDI);
    end

    // ---------------- TAP model ----------------
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t        tap   = TLR;
    logic [2:0]  ir    = 3'b111;
    logic [2:0]  ir_sr = 3'b000;
    logic        byp   = 1'b0;
    logic [252:0] bsr  = '0;
    logic [252:0] bsr_cap;

    initial begin
        for (int i = 0; i < 253; i++) bsr_cap[i] = (i % 3 == 0);
    end

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tap)
            TLR:   ir <= 3'b111;
            CAPIR: ir_sr <= 3'b001;
            SHIR:  ir_sr <= {TDI, ir_sr[2:1]};
            UPIR:  ir <= ir_sr;
            CAPDR: if (ir == 3'b010) bsr <= bsr_cap; else byp <= 1'b0;
            SHDR:  if (ir == 3'b010) bsr <= {TDI, bsr[252:1]}; else byp <= TDI;
            default: ;
        endcase
        tap <= tap_next(tap, TMS);
    end

    always @(negedge TCK) begin
        if (tap == SHIR)      TDO <= ir_sr[0];
        else if (tap == SHDR) TDO <= (ir == 3'b010) ? bsr[0] : byp;
        else                  TDO <= 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] len, input logic [255:0] data);
        int n = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        while (!cmd_ready && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_len   = '1;
        cmd_data  = '1;
    endtask

    // Returns on the first cycle rsp_valid is seen; lat counts cycles from the accept cycle.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 3000) begin
            @(negedge wb_clk_i);
            lat++;
        end
        vec_cnt++;
        if (rsp_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
        end
    endtask

    task automatic load_exp(input int n, input logic [31:0] pat, inout logic exp_q[$]);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(pat[i]);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        int base;
        logic exp_q[$];
        resetn = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        vec_cnt++; if (TCK !== 1'b0)       begin err_cnt++; $display("FAIL rst_tck: got %b exp 0", TCK); end
        vec_cnt++; if (TMS !== 1'b1)       begin err_cnt++; $display("FAIL rst_tms: got %b exp 1", TMS); end
        vec_cnt++; if (TDI !== 1'b0)       begin err_cnt++; $display("FAIL rst_tdi: got %b exp 0", TDI); end
        vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
        vec_cnt++; if (rsp_data !== '0)    begin err_cnt++; $display("FAIL rst_rsp_data: got %h exp 0", rsp_data); end
        vec_cnt++; if (rsp_err !== 1'b0)   begin err_cnt++; $display("FAIL rst_rsp_err: got %b exp 0", rsp_err); end
        vec_cnt++; if (busy !== 1'b1)      begin err_cnt++; $display("FAIL rst_busy: got %b exp 1", busy); end
        base = tms_log.size();
        resetn = 1'b1;
        cyc = 1;
        while (!cmd_ready && cyc < 100) begin
            @(negedge wb_clk_i);
            cyc++;
        end
        vec_cnt++; if (cyc != 25)     begin err_cnt++; $display("FAIL init_ready_cycle: got %0d exp 25", cyc); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL init_busy: got %b exp 0", busy); end
        load_exp(6, 32'h1F, exp_q);
        vec_cnt++;
        if (tms_log.size() - base != 6) begin
            err_cnt++; $display("FAIL init_edges: got %0d exp 6", tms_log.size() - base);
        end
        for (int i = 0; i < 6 && base + i < tms_log.size(); i++) begin
            vec_cnt++;
            if (tms_log[base+i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL init_tms[%0d]: got %b exp %b", i, tms_log[base+i], exp_q[i]);
            end
        end
        vec_cnt++; if (tap != RTI) begin err_cnt++; $display("FAIL init_tap_state: got %0d exp %0d", tap, RTI); end
    endtask

    task automatic test_scan_ir();
        int base;
        int lat;
        logic exp_q[$];
        logic [2:0] exp_tdi = 3'b010;
        base = tms_log.size();
        send_cmd(2'b01, 8'd2, 256'h2);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== 256'h1) begin err_cnt++; $display("FAIL ir_rsp_data: got %h exp 1", rsp_data); end
        vec_cnt++; if (rsp_err !== 1'b0)    begin err_cnt++; $display("FAIL ir_rsp_err: got %b exp 0", rsp_err); end
        vec_cnt++; if (lat != 37)           begin err_cnt++; $display("FAIL ir_latency: got %0d exp 37", lat); end
        vec_cnt++;
        if (tms_log.size() - base != 9) begin
            err_cnt++; $display("FAIL ir_edges: got %0d exp 9", tms_log.size() - base);
        end
        load_exp(9, 32'h0C3, exp_q);
        for (int i = 0; i < 9 && base + i < tms_log.size(); i++) begin
            vec_cnt++;
            if (tms_log[base+i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL ir_tms[%0d]: got %b exp %b", i, tms_log[base+i], exp_q[i]);
            end
        end
        for (int i = 0; i < 3 && base + 4 + i < tdi_log.size(); i++) begin
            vec_cnt++;
            if (tdi_log[base+4+i] !== exp_tdi[i]) begin
                err_cnt++; $display("FAIL ir_tdi[%0d]: got %b exp %b", i, tdi_log[base+4+i], exp_tdi[i]);
            end
        end
        vec_cnt++; if (ir !== 3'b010) begin err_cnt++; $display("FAIL ir_loaded: got %b exp 010", ir); end
        vec_cnt++; if (tap != RTI)    begin err_cnt++; $display("FAIL ir_tap_state: got %0d exp %0d", tap, RTI); end
    endtask

    task automatic test_dr_bsr();
        int base;
        int lat;
        logic [7:0] d = 8'hA5;
        base = tms_log.size();
        send_cmd(2'b10, 8'd7, 256'hA5);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== 256'h49) begin err_cnt++; $display("FAIL bsr_rsp_data: got %h exp 49", rsp_data); end
        vec_cnt++; if (lat != 53)            begin err_cnt++; $display("FAIL bsr_latency: got %0d exp 53", lat); end
        vec_cnt++;
        if (tms_log.size() - base != 13) begin
            err_cnt++; $display("FAIL bsr_edges: got %0d exp 13", tms_log.size() - base);
        end
        for (int i = 0; i < 8 && base + 3 + i < tdi_log.size(); i++) begin
            vec_cnt++;
            if (tdi_log[base+3+i] !== d[i]) begin
                err_cnt++; $display("FAIL bsr_tdi[%0d]: got %b exp %b", i, tdi_log[base+3+i], d[i]);
            end
        end
        vec_cnt++; if (bsr[252:245] !== 8'hA5) begin err_cnt++; $display("FAIL bsr_shifted_in: got %h exp a5", bsr[252:245]); end
        vec_cnt++; if (tap != RTI) begin err_cnt++; $display("FAIL bsr_tap_state: got %0d exp %0d", tap, RTI); end
    endtask

    task automatic test_single_bit();
        int base;
        int lat;
        logic exp_q[$];
        base = tms_log.size();
        send_cmd(2'b10, 8'd0, 256'h1);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== 256'h1) begin err_cnt++; $display("FAIL n1_rsp_data: got %h exp 1", rsp_data); end
        vec_cnt++; if (lat != 25)           begin err_cnt++; $display("FAIL n1_latency: got %0d exp 25", lat); end
        vec_cnt++;
        if (tms_log.size() - base != 6) begin
            err_cnt++; $display("FAIL n1_edges: got %0d exp 6", tms_log.size() - base);
        end
        load_exp(6, 32'h19, exp_q);
        for (int i = 0; i < 6 && base + i < tms_log.size(); i++) begin
            vec_cnt++;
            if (tms_log[base+i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL n1_tms[%0d]: got %b exp %b", i, tms_log[base+i], exp_q[i]);
            end
        end
        vec_cnt++; if (bsr[252] !== 1'b1) begin err_cnt++; $display("FAIL n1_tdi_bit: got %b exp 1", bsr[252]); end
    endtask

    task automatic test_bypass_long();
        int base;
        int lat;
        logic [255:0] d;
        logic [255:0] exp_d;
        send_cmd(2'b01, 8'd2, 256'h7);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== 256'h1) begin err_cnt++; $display("FAIL byp_ir_rsp: got %h exp 1", rsp_data); end
        vec_cnt++; if (ir !== 3'b111)       begin err_cnt++; $display("FAIL byp_ir_loaded: got %b exp 111", ir); end
        d     = {128{2'b10}};
        exp_d = {3'b000, d[251:0], 1'b0};
        base  = tms_log.size();
        send_cmd(2'b10, 8'd252, d);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== exp_d) begin err_cnt++; $display("FAIL byp_rsp_data: got %h exp %h", rsp_data, exp_d); end
        vec_cnt++; if (lat != 1033)        begin err_cnt++; $display("FAIL byp_latency: got %0d exp 1033", lat); end
        vec_cnt++;
        if (tms_log.size() - base != 258) begin
            err_cnt++; $display("FAIL byp_edges: got %0d exp 258", tms_log.size() - base);
        end
        vec_cnt++; if (tap != RTI) begin err_cnt++; $display("FAIL byp_tap_state: got %0d exp %0d", tap, RTI); end
    endtask

    task automatic test_backpressure();
        int lat;
        int edges;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        send_cmd(2'b01, 8'd2, 256'h2);
        wait_rsp(lat);
        edges = tms_log.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            vec_cnt++; if (rsp_valid !== 1'b1)  begin err_cnt++; $display("FAIL hold_rsp_valid[%0d]: got %b exp 1", i, rsp_valid); end
            vec_cnt++; if (rsp_data !== 256'h1) begin err_cnt++; $display("FAIL hold_rsp_data[%0d]: got %h exp 1", i, rsp_data); end
            vec_cnt++; if (cmd_ready !== 1'b0)  begin err_cnt++; $display("FAIL hold_cmd_ready[%0d]: got %b exp 0", i, cmd_ready); end
            vec_cnt++;
            if (tms_log.size() != edges) begin
                err_cnt++; $display("FAIL hold_tck[%0d]: got %0d edges exp 0", i, tms_log.size() - edges);
            end
        end
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL release_cmd_ready: got %b exp 1", cmd_ready); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL release_rsp_valid: got %b exp 0", rsp_valid); end
        vec_cnt++; if (ir !== 3'b010)      begin err_cnt++; $display("FAIL hold_ir_loaded: got %b exp 010", ir); end
    endtask

    task automatic test_tap_reset();
        int base;
        int lat;
        logic exp_q[$];
        base = tms_log.size();
        send_cmd(2'b00, 8'd9, 256'hFF);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== '0)  begin err_cnt++; $display("FAIL trst_rsp_data: got %h exp 0", rsp_data); end
        vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL trst_rsp_err: got %b exp 0", rsp_err); end
        vec_cnt++; if (lat != 25)        begin err_cnt++; $display("FAIL trst_latency: got %0d exp 25", lat); end
        vec_cnt++;
        if (tms_log.size() - base != 6) begin
            err_cnt++; $display("FAIL trst_edges: got %0d exp 6", tms_log.size() - base);
        end
        load_exp(6, 32'h1F, exp_q);
        for (int i = 0; i < 6 && base + i < tms_log.size(); i++) begin
            vec_cnt++;
            if (tms_log[base+i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL trst_tms[%0d]: got %b exp %b", i, tms_log[base+i], exp_q[i]);
            end
        end
        vec_cnt++; if (ir !== 3'b111) begin err_cnt++; $display("FAIL trst_ir: got %b exp 111", ir); end
        vec_cnt++; if (tap != RTI)    begin err_cnt++; $display("FAIL trst_tap_state: got %0d exp %0d", tap, RTI); end
    endtask

    task automatic test_reserved();
        int base;
        int lat;
        base = tms_log.size();
        send_cmd(2'b11, 8'd5, 256'hFF);
        wait_rsp(lat);
        vec_cnt++; if (lat != 1)           begin err_cnt++; $display("FAIL rsv_latency: got %0d exp 1", lat); end
        vec_cnt++; if (rsp_err !== 1'b1)   begin err_cnt++; $display("FAIL rsv_rsp_err: got %b exp 1", rsp_err); end
        vec_cnt++; if (rsp_data !== '0)    begin err_cnt++; $display("FAIL rsv_rsp_data: got %h exp 0", rsp_data); end
        vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rsv_cmd_ready: got %b exp 0", cmd_ready); end
        vec_cnt++; if (busy !== 1'b1)      begin err_cnt++; $display("FAIL rsv_busy: got %b exp 1", busy); end
        vec_cnt++;
        if (tms_log.size() != base) begin
            err_cnt++; $display("FAIL rsv_edges: got %0d exp 0", tms_log.size() - base);
        end
    endtask

    task automatic test_reset_mid_scan();
        int base;
        int n = 0;
        int cyc;
        int lat;
        logic exp_q[$];
        base = tms_log.size();
        send_cmd(2'b10, 8'd199, {64{4'h6}});
        while (tms_log.size() - base < 103 && n < 1000) begin
            @(negedge wb_clk_i);
            n++;
        end
        vec_cnt++; if (TCK !== 1'b1) begin err_cnt++; $display("FAIL mid_tck_high: got %b exp 1", TCK); end
        resetn = 1'b0;
        #1;
        vec_cnt++; if (TCK !== 1'b0)       begin err_cnt++; $display("FAIL mid_rst_tck: got %b exp 0", TCK); end
        vec_cnt++; if (TMS !== 1'b1)       begin err_cnt++; $display("FAIL mid_rst_tms: got %b exp 1", TMS); end
        vec_cnt++; if (TDI !== 1'b0)       begin err_cnt++; $display("FAIL mid_rst_tdi: got %b exp 0", TDI); end
        vec_cnt++; if (busy !== 1'b1)      begin err_cnt++; $display("FAIL mid_rst_busy: got %b exp 1", busy); end
        vec_cnt++; if (rsp_data !== '0)    begin err_cnt++; $display("FAIL mid_rst_rsp_data: got %h exp 0", rsp_data); end
        repeat (5) @(negedge wb_clk_i);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_rsp_valid: got %b exp 0", rsp_valid); end
        base = tms_log.size();
        resetn = 1'b1;
        cyc = 1;
        while (!cmd_ready && cyc < 100) begin
            @(negedge wb_clk_i);
            vec_cnt++;
            if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_reinit_rsp_valid: got %b exp 0", rsp_valid); end
            cyc++;
        end
        vec_cnt++; if (cyc != 25) begin err_cnt++; $display("FAIL mid_reinit_cycle: got %0d exp 25", cyc); end
        load_exp(6, 32'h1F, exp_q);
        vec_cnt++;
        if (tms_log.size() - base != 6) begin
            err_cnt++; $display("FAIL mid_reinit_edges: got %0d exp 6", tms_log.size() - base);
        end
        for (int i = 0; i < 6 && base + i < tms_log.size(); i++) begin
            vec_cnt++;
            if (tms_log[base+i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL mid_reinit_tms[%0d]: got %b exp %b", i, tms_log[base+i], exp_q[i]);
            end
        end
        send_cmd(2'b01, 8'd2, 256'h5);
        wait_rsp(lat);
        vec_cnt++; if (rsp_data !== 256'h1) begin err_cnt++; $display("FAIL mid_ir_rsp: got %h exp 1", rsp_data); end
        vec_cnt++; if (ir !== 3'b101)       begin err_cnt++; $display("FAIL mid_ir_loaded: got %b exp 101", ir); end
        vec_cnt++; if (tap != RTI)          begin err_cnt++; $display("FAIL mid_tap_state: got %0d exp %0d", tap, RTI); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_scan_ir();
        test_dr_bsr();
        test_single_bit();
        test_bypass_long();
        test_backpressure();
        test_tap_reset();
        test_reserved();
        test_reset_mid_scan();
        repeat (4) @(negedge wb_clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
